// File: rtl/fetch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fetch_pkg
// Purpose  : Shared widths, state encodings and helpers for the fetch stage.
// Revision : 1.0
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    // Instructions are word aligned, so redirect targets drop the byte offset.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return addr & {{(PC_W-2){1'b1}}, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifid_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : ifid_reg
// Purpose  : IF/ID pipeline register; clear inserts a bubble and beats load.
// Revision : 1.0
// ----------------------------------------------------------------------------
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [PC_W-1:0]    pc4_d,
    output logic [INSTR_W-1:0] instr_q,
    output logic [PC_W-1:0]    pc4_q,
    output logic               valid_q
);

    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc4;
    logic               r_valid;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_instr <= INSTR_W'(NOP_INSTR);
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_instr <= instr_d;
            r_pc4   <= pc4_d;
            r_valid <= 1'b1;
        end
    end

    assign instr_q = r_instr;
    assign pc4_q   = r_pc4;
    assign valid_q = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fetch_unit
// Purpose  : Instruction fetch stage: PC, next-PC selection, FSM and IF/ID.
// Revision : 1.0
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                          PC_W     = fetch_pkg::PC_W,
    parameter int                          INSTR_W  = fetch_pkg::INSTR_W,
    parameter logic [fetch_pkg::PC_W-1:0]  RESET_PC = 8'h00,
    parameter int                          PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    FETCH_IMEM_PC,
    input  logic [INSTR_W-1:0] FETCH_IMEM_instruction,
    input  logic               FETCH_stall,
    input  logic               FETCH_branch_taken,
    input  logic [PC_W-1:0]    FETCH_branch_target,
    input  logic               FETCH_jump,
    input  logic [PC_W-1:0]    FETCH_jump_target,
    output logic [INSTR_W-1:0] IFID_instruction,
    output logic [PC_W-1:0]    IFID_pc_plus4,
    output logic               IFID_valid,
    output logic [1:0]         FETCH_state
);

    import fetch_pkg::*;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_load;
    logic            w_clear;

    assign w_pc_inc = r_pc + PC_W'(PC_STEP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // The unused encoding falls into the default arm and recovers to RUN.
    always_comb begin
        w_state_next = ST_RUN;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            default: begin
                if (FETCH_branch_taken || FETCH_jump) begin
                    w_state_next = ST_RUN;
                end else if (FETCH_stall) begin
                    w_state_next = ST_STALL;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
        endcase
    end

    // Branch (EX) is older than jump (ID); both outrank the hazard hold.
    always_comb begin
        w_pc_next = r_pc;
        w_load    = 1'b0;
        w_clear   = 1'b0;
        if (r_state != ST_BOOT) begin
            if (FETCH_branch_taken) begin
                w_pc_next = align_pc(FETCH_branch_target);
                w_clear   = 1'b1;
            end else if (FETCH_jump) begin
                w_pc_next = align_pc(FETCH_jump_target);
                w_clear   = 1'b1;
            end else if (!FETCH_stall) begin
                w_pc_next = w_pc_inc;
                w_load    = 1'b1;
            end
        end
    end

    ifid_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_ifid_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .clear   (w_clear),
        .instr_d (FETCH_IMEM_instruction),
        .pc4_d   (w_pc_inc),
        .instr_q (IFID_instruction),
        .pc4_q   (IFID_pc_plus4),
        .valid_q (IFID_valid)
    );

    assign FETCH_IMEM_PC = r_pc;
    assign FETCH_state   = r_state;

endmodule
`default_nettype wire
